md_unit: RTL and testbench

Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS datapath. It sits beside the combinational ALU in the EX stage. It accepts signed and unsigned multiply/divide plus MTHI/MTLO writes, and models multi-cycle latency with a busy flag so the hazard unit can stall MFHI/MFLO and further MD instructions. Result width, multiply latency and divide latency are parameters.

---
 rtl/md_pkg.sv | 15 +
 rtl/md_arith.sv | 58 +++++
 rtl/md_unit.sv | 69 ++++++
 tb/tb_md_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the latency counter width.
package md_pkg;
  localparam int CNT_W = 8;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
endpackage

// File: rtl/md_arith.sv
// Combinational MIPS multiply/divide datapath producing {hi, lo}, including
// the divide-by-zero and signed-overflow results.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  output logic [2*WIDTH-1:0] res
);
  logic signed [2*WIDTH-1:0] w_sprod;
  logic        [2*WIDTH-1:0] w_uprod;
  logic                      w_bzero;
  logic                      w_ovf;
  logic signed [WIDTH-1:0]   w_sa;
  logic signed [WIDTH-1:0]   w_sb;
  logic        [WIDTH-1:0]   w_ub;
  logic signed [WIDTH-1:0]   w_squo;
  logic signed [WIDTH-1:0]   w_srem;
  logic        [WIDTH-1:0]   w_uquo;
  logic        [WIDTH-1:0]   w_urem;

  assign w_sprod = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign w_uprod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign w_bzero = (B == '0);
  assign w_ovf   = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

  // Special cases are muxed out below; feed the dividers a harmless divisor
  // so they never see x/0 or MIN/-1.
  assign w_sa   = $signed(A);
  assign w_sb   = (w_bzero || w_ovf) ? WIDTH'(1) : $signed(B);
  assign w_ub   = w_bzero ? WIDTH'(1) : B;
  assign w_squo = w_sa / w_sb;
  assign w_srem = w_sa % w_sb;
  assign w_uquo = A / w_ub;
  assign w_urem = A % w_ub;

  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = w_sprod;
      MD_MULTU: res = w_uprod;
      MD_DIV: begin
        if (w_bzero)    res = {A, {WIDTH{1'b1}}};
        else if (w_ovf) res = {{WIDTH{1'b0}}, A};
        else            res = {w_srem, w_squo};
      end
      MD_DIVU: begin
        if (w_bzero) res = {A, {WIDTH{1'b1}}};
        else         res = {w_urem, w_uquo};
      end
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO; the result is
// computed at issue and held pending until the modelled latency expires.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_pend_hi;
  logic [WIDTH-1:0]   r_pend_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] w_res;
  logic               w_is_md;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .A   (A),
    .B   (B),
    .op  (op),
    .res (w_res)
  );

  assign w_is_md = (op[2] == 1'b0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == IDLE) begin
      if (start && w_is_md) begin
        {r_pend_hi, r_pend_lo} <= w_res;
        r_cnt   <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        r_state <= RUN;
      end else if (start && op == MD_MTHI) begin
        r_hi <= A;
      end else if (start && op == MD_MTLO) begin
        r_lo <= A;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_hi    <= r_pend_hi;
        r_lo    <= r_pend_lo;
        r_state <= IDLE;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a cycle-count/64-bit-arithmetic reference model
// checked every cycle, plus hand-computed literal checks.
module tb_md_unit;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  md_unit #(.WIDTH(32), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic in 64-bit integers; MIN/-1 falls out naturally.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    ref_res = '0;
    case (o)
      3'd0: ref_res = 64'(sa * sb);
      3'd1: ref_res = ua * ub;
      3'd2: if (b == 0) ref_res = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb; r = sa % sb; ref_res = {r[31:0], q[31:0]}; end
      3'd3: if (b == 0) ref_res = {a, 32'hFFFF_FFFF};
            else begin uq = ua / ub; ur = ua % ub; ref_res = {ur[31:0], uq[31:0]}; end
      default: ref_res = '0;
    endcase
  endfunction

  // Model: an accepted op finishes at the edge numbered accept+N.
  longint      cyc = 0, done_at = 0;
  bit          m_busy = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_busy) begin
      if (cyc == done_at) begin m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; end
    end else if (start) begin
      if (op <= 3'd3) begin
        {p_hi, p_lo} = ref_res(op, A, B);
        done_at = cyc + ((op >= 3'd2) ? DIVN : MULN);
        m_busy = 1'b1;
      end else if (op == 3'd4) m_hi = A;
      else if (op == 3'd5) m_lo = A;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0; op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(input string nm, input int expn);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    chk(nm, n, expn);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b110; A = '0; B = '0;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult_lat", MULN);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);          // back-to-back, first idle cycle
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_idle("multu_lat", MULN);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_lat", DIVN);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'h0000_1234, 32'd0);
    wait_idle("divu0_lat", DIVN);
    chk("divu0_hi", hi, 32'h0000_1234);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("ovf_lat", DIVN);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    issue(3'd4, 32'hA5A5_A5A5, 32'd0);
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo", lo, 32'h8000_0000);
    chk("mthi_busy", {31'b0, busy}, 32'd0);

    issue(3'd2, 32'd100, 32'd7);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);          // ignored while busy
    wait_idle("div_mtlo_lat", DIVN - 1);
    chk("mtlo_ign_lo", lo, 32'd14);
    chk("mtlo_ign_hi", hi, 32'd2);

    issue(3'd6, 32'h1111_1111, 32'h2222_2222);  // no-op
    chk("nop_hi", hi, 32'd2);
    chk("nop_lo", lo, 32'd14);

    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_neg_lat", DIVN);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'd1);

    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_idle("mult_min_lat", MULN);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0000_0000);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu_max_lat", MULN);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    issue(3'd3, 32'hFFFF_FFFF, 32'h10);
    wait_idle("divu_lat", DIVN);
    chk("divu_lo", lo, 32'h0FFF_FFFF);
    chk("divu_hi", hi, 32'h0000_000F);

    issue(3'd2, 32'hFFFF_FFFB, 32'd0);
    wait_idle("div0_lat", DIVN);
    chk("div0_hi", hi, 32'hFFFF_FFFB);
    chk("div0_lo", lo, 32'hFFFF_FFFF);

    // Abort a DIV on its 4th busy cycle; reset also beats a coincident start.
    issue(3'd2, 32'd50, 32'd5);
    step(); step(); step();
    reset = 1'b1; start = 1'b1; op = 3'd0; A = 32'd9; B = 32'd9;
    step();
    reset = 1'b0; start = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) step();
    chk("abort_stale_lo", lo, 32'd0);

    issue(3'd0, 32'd6, 32'd7);
    wait_idle("post_rst_lat", MULN);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);

    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
